// File: rtl/nibble_add_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_add_pkg;
  localparam int NW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/foutbit.sv
// 4-bit ripple-carry adder built from four full-adder cells.
module foutbit (
  input  logic cin,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic cout,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3
);
  logic c1, c2, c3;

  assign s0   = a0 ^ b0 ^ cin;
  assign c1   = (a0 & b0) | (cin & (a0 ^ b0));
  assign s1   = a1 ^ b1 ^ c1;
  assign c2   = (a1 & b1) | (c1 & (a1 ^ b1));
  assign s2   = a2 ^ b2 ^ c2;
  assign c3   = (a2 & b2) | (c2 & (a2 ^ b2));
  assign s3   = a3 ^ b3 ^ c3;
  assign cout = (a3 & b3) | (c3 & (a3 ^ b3));
endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial add/subtract: one shared 4-bit adder, LSB nibble first,
// result after NIBBLES RUN cycles with a one-cycle done pulse.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [NW*NIBBLES-1:0] a,
  input  logic [NW*NIBBLES-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [NW*NIBBLES-1:0] sum,
  output logic                  cout
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t state, state_nx;

  logic [NIBBLES-1:0][NW-1:0] a_q, b_q, sum_q;
  logic                       sub_q, carry, cout_q;
  logic [IW-1:0]              idx;
  logic [NW-1:0]              an, bn, sn;
  logic                       co, accept, last;

  always_comb begin
    accept   = start && (state != RUN);
    last     = (idx == LAST);
    an       = a_q[idx];
    // subtract is a + ~b + 1; the +1 comes from the carry seeded at accept
    bn       = sub_q ? ~b_q[idx] : b_q[idx];
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last)   state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  foutbit u_add (
    .cin (carry),
    .a0  (an[0]), .a1(an[1]), .a2(an[2]), .a3(an[3]),
    .b0  (bn[0]), .b1(bn[1]), .b2(bn[2]), .b3(bn[3]),
    .cout(co),
    .s0  (sn[0]), .s1(sn[1]), .s2(sn[2]), .s3(sn[3])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        sub_q  <= sub;
        carry  <= sub ? 1'b1 : cin;
        idx    <= '0;
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else if (state == RUN) begin
        sum_q[idx] <= sn;
        carry      <= co;
        idx        <= idx + IW'(1);
        // cout mirrors the final carry so it stays 0 until the result is ready
        if (last) cout_q <= co;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, the number of 4-bit digits per operand (range 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one operation; sampled on the rising edge of clk.
REQ-005 SHALL have port sub  input  1  mode select: 0 = add, 1 = subtract; sampled with start.
REQ-006 SHALL have port cin  input  1  carry-in for add mode; ignored in subtract mode.
REQ-007 SHALL have port a  input  4*NIBBLES  operand A; sampled with start.
REQ-008 SHALL have port b  input  4*NIBBLES  operand B; sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when sum and cout become valid.
REQ-011 SHALL have port sum  output  4*NIBBLES  result.
REQ-012 SHALL have port cout  output  1  final carry-out; in subtract mode 1 = no borrow.

Function
REQ-013 SHALL compute the full-width result using exactly one 4-bit ripple adder, applied to one nibble per clock cycle, least-significant nibble first.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, latch a, b and sub into internal registers; set the carry register to cin (add mode) or 1 (subtract mode); clear the nibble index to 0; and move to RUN.
REQ-016 SHALL, in subtract mode, feed the bitwise inverse of each latched b nibble to the adder.
REQ-017 SHALL, in each RUN cycle, write the adder sum into sum nibble [index], load the adder carry-out into the carry register, and increment the index.
REQ-018 SHALL move from RUN to DONE on the cycle that processes nibble NIBBLES-1, and SHALL drive cout from the carry register.
REQ-019 SHALL hold done high for exactly the one DONE cycle, then return to IDLE unless start=1 in that cycle.
REQ-020 SHALL have fixed latency: with start sampled at edge k, done SHALL be high during the cycle following edge k+NIBBLES.
REQ-021 SHALL hold busy high in RUN only; busy SHALL be low in IDLE and DONE.
REQ-022 SHALL ignore start while busy=1; the latched operands SHALL be unaffected.
REQ-023 SHALL hold sum and cout stable from done until the next accepted start; on an accepted start, sum and cout SHALL clear to 0.
REQ-024 SHALL, when start=1 arrives in DONE, pulse done for that cycle and enter RUN on the next edge, with no idle gap.
REQ-025 SHALL discard all carry beyond cout; sum wraps modulo 2^(4*NIBBLES).

Reset
REQ-026 SHALL, when rst=1 at a rising edge, enter IDLE; clear busy, done, sum, cout, the carry register and the index to 0; and abort any operation in progress.
REQ-027 SHALL give rst priority over start in the same cycle.

Structure
REQ-028 SHALL place the FSM state encodings and the nibble width constant (4) in the shared package nibble_add_pkg.
REQ-029 SHALL instantiate the team's existing 4-bit ripple adder foutbit as its single sub-module, with ports cin, a0..a3, b0..b3, cout and s0..s3.
REQ-030 SHALL contain no other arithmetic on operand data besides the foutbit instance and the nibble-index counter.

Verification (NIBBLES=4)
REQ-031 SHALL cover: start, add, a=0x00FF, b=0x0001, cin=0 -> done at edge k+5, sum=0x0100, cout=0; busy high for 4 cycles.
REQ-032 SHALL cover: add, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
REQ-033 SHALL cover: subtract, a=0x1234, b=0x0235 -> sum=0x0FFF, cout=1; subtract, a=0x0000, b=0x0001 -> sum=0xFFFF, cout=0.
REQ-034 SHALL cover: start re-pulsed with new operands during RUN -> ignored; result matches the first operands only.
REQ-035 SHALL cover: start held high across DONE -> back-to-back operations, done pulses exactly 5 cycles apart.
REQ-036 SHALL cover: rst asserted at the second RUN cycle -> next cycle busy=0, done=0, sum=0x0000, cout=0, state IDLE; no done pulse follows.
